// File: rtl/addr_bank_fifo.sv
// addr_bank_fifo: address-decoded bank of per-channel first-word-fall-through FIFOs
// Ports: clk/rstn (async active-low); wr_en/wr_addr/wr_data write, routed by address region;
// rd_en/rd_sel pop (lockstep or per-channel per RD_MODE); rd_data/rd_valid heads and pop-ready;
// full/empty/count per-channel status; err_ovf/err_range sticky drop flags, cleared by err_clr.
module addr_bank_fifo #(
  parameter int N_CH = 4,
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int BASE_ADDR = 0,
  parameter int REGION_BYTES = DEPTH * 4,
  parameter int RD_MODE = 0
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 wr_en,
  input  logic [31:0]                          wr_addr,
  input  logic [WIDTH-1:0]                     wr_data,
  input  logic                                 rd_en,
  input  logic [$clog2(N_CH)-1:0]              rd_sel,
  output logic [N_CH*WIDTH-1:0]                rd_data,
  output logic                                 rd_valid,
  output logic [N_CH-1:0]                      full,
  output logic [N_CH-1:0]                      empty,
  output logic [N_CH*($clog2(DEPTH)+1)-1:0]    count,
  output logic                                 err_ovf,
  output logic                                 err_range,
  input  logic                                 err_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(N_CH);
  localparam int RB = $clog2(REGION_BYTES);
  logic [32:0] a, off;
  logic [CW-1:0] ch;
  logic [N_CH-1:0] pop;
  logic in_range, sel_ok, wr_acc, ovf_set, rng_set, unused_hi;
  assign unused_hi = ^wr_addr[31:28];
  // 33-bit arithmetic so BASE_ADDR + region span cannot wrap
  assign a = {5'd0, wr_addr[27:0]};
  assign off = a - 33'(BASE_ADDR);
  assign in_range = a >= 33'(BASE_ADDR) && a < 33'(BASE_ADDR) + 33'(N_CH) * 33'(REGION_BYTES);
  assign ch = CW'(off >> RB);
  assign sel_ok = 32'(rd_sel) < N_CH;
  assign rd_valid = RD_MODE == 0 ? &(~empty) : sel_ok && !empty[rd_sel];
  // a full channel still accepts when it is popped in the same cycle
  assign wr_acc = wr_en && in_range && (!full[ch] || pop[ch]);
  assign ovf_set = wr_en && in_range && full[ch] && !pop[ch];
  assign rng_set = wr_en && !in_range;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      err_ovf <= 1'b0;
      err_range <= 1'b0;
    end else begin
      err_ovf <= ovf_set || (err_ovf && !err_clr);
      err_range <= rng_set || (err_range && !err_clr);
    end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic we;
    assign we = wr_acc && ch == CW'(i);
    assign pop[i] = rd_en && rd_valid && (RD_MODE == 0 || rd_sel == CW'(i));
    always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
      end else begin
        if (we) wp <= wp + 1'b1;
        if (pop[i]) rp <= rp + 1'b1;
        cnt <= cnt + {{AW{1'b0}}, we} - {{AW{1'b0}}, pop[i]};
      end
    always_ff @(posedge clk)
      if (we) mem[wp] <= wr_data;
    assign full[i] = cnt == (AW+1)'(DEPTH);
    assign empty[i] = cnt == '0;
    assign count[i*(AW+1) +: AW+1] = cnt;
    assign rd_data[i*WIDTH +: WIDTH] = empty[i] ? '0 : mem[rp];
  end
endmodule

// File: tb/tb_addr_bank_fifo.sv
// tb_addr_bank_fifo: lockstep and independent-read instances checked against queue models
module tb_addr_bank_fifo;
  localparam int N = 4, D = 4, W = 32, RB = 16, BASE = 0;
  logic clk = 0, rstn = 0, wr_en = 0, rd_en = 0, err_clr = 0;
  logic [31:0] wr_addr = 0;
  logic [W-1:0] wr_data = 0;
  logic [1:0] rd_sel = 0;
  logic [N*W-1:0] rd_data [2];
  logic rd_valid [2], err_ovf [2], err_range [2];
  logic [N-1:0] full [2], empty [2];
  logic [N*3-1:0] count [2];
  int checks = 0, errors = 0;
  logic [W-1:0] q [2][N][$];
  bit m_ovf [2], m_rng [2];
  always #5 clk = ~clk;
  for (genvar m = 0; m < 2; m++) begin : g_dut
    addr_bank_fifo #(.RD_MODE(m)) u (
      .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data[m]), .rd_valid(rd_valid[m]),
      .full(full[m]), .empty(empty[m]), .count(count[m]), .err_ovf(err_ovf[m]),
      .err_range(err_range[m]), .err_clr(err_clr)
    );
  end
  function automatic bit exp_valid(int m);
    bit v = 1;
    if (m == 1) return q[1][rd_sel].size() > 0;
    for (int i = 0; i < N; i++) if (q[0][i].size() == 0) v = 0;
    return v;
  endfunction
  task automatic model_step;
    longint a, ch;
    bit inr, v, was_full, so, sr;
    bit pop [N];
    a = longint'(wr_addr[27:0]);
    inr = a >= BASE && a < BASE + N * RB;
    ch = inr ? (a - BASE) / RB : 0;
    for (int m = 0; m < 2; m++) begin
      v = exp_valid(m);
      for (int i = 0; i < N; i++) pop[i] = rd_en && v && (m == 0 || rd_sel == 2'(i));
      was_full = q[m][ch].size() == D;
      so = 0;
      sr = 0;
      for (int i = 0; i < N; i++) if (pop[i]) void'(q[m][i].pop_front());
      if (wr_en && !inr) sr = 1;
      else if (wr_en && (!was_full || pop[ch])) q[m][ch].push_back(wr_data);
      else if (wr_en) so = 1;
      m_ovf[m] = so || (m_ovf[m] && !err_clr);
      m_rng[m] = sr || (m_rng[m] && !err_clr);
    end
  endtask
  task automatic step;
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic wr(input logic [31:0] ad, input logic [W-1:0] dt);
    wr_en = 1;
    wr_addr = ad;
    wr_data = dt;
    step();
    wr_en = 0;
  endtask
  task automatic do_reset;
    wr_en = 0;
    rd_en = 0;
    err_clr = 0;
    rd_sel = 0;
    rstn = 0;
    #3;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < N; i++) q[m][i].delete();
      m_ovf[m] = 0;
      m_rng[m] = 0;
    end
    rstn = 1;
  endtask
  task automatic test_reset;
    #2;
    for (int m = 0; m < 2; m++) begin
      checks++; if (empty[m] !== 4'hf) begin errors++; $display("FAIL reset_empty[%0d]: got %h exp f", m, empty[m]); end
      checks++; if (count[m] !== 12'h0) begin errors++; $display("FAIL reset_count[%0d]: got %h exp 0", m, count[m]); end
      checks++; if (rd_data[m] !== '0) begin errors++; $display("FAIL reset_rd_data[%0d]: got %h exp 0", m, rd_data[m]); end
      checks++; if ({rd_valid[m], full[m], err_ovf[m], err_range[m]} !== 7'b0) begin errors++; $display("FAIL reset_flags[%0d]: got %b exp 0", m, {rd_valid[m], full[m], err_ovf[m], err_range[m]}); end
    end
    do_reset();
  endtask
  task automatic test_basic;
    do_reset();
    wr(32'h00, 32'hA0);
    wr(32'h10, 32'hB0);
    checks++; if (empty[0] !== 4'b1100) begin errors++; $display("FAIL basic_empty: got %b exp 1100", empty[0]); end
    checks++; if (count[0][5:0] !== 6'b001_001) begin errors++; $display("FAIL basic_count: got %b exp 001001", count[0][5:0]); end
    checks++; if (rd_data[0][31:0] !== 32'hA0) begin errors++; $display("FAIL basic_head0: got %h exp a0", rd_data[0][31:0]); end
    checks++; if (rd_data[0][63:32] !== 32'hB0) begin errors++; $display("FAIL basic_head1: got %h exp b0", rd_data[0][63:32]); end
  endtask
  task automatic test_lockstep;
    do_reset();
    for (int i = 0; i < 3; i++) wr(32'(i * RB), 32'(i + 1));
    rd_en = 1;
    #1;
    checks++; if (rd_valid[0] !== 1'b0) begin errors++; $display("FAIL lock_valid_lo: got %b exp 0", rd_valid[0]); end
    step();
    rd_en = 0;
    checks++; if (count[0] !== 12'h049) begin errors++; $display("FAIL lock_nopop: got %h exp 049", count[0]); end
    wr(32'h30, 32'h4);
    rd_en = 1;
    #1;
    checks++; if (rd_valid[0] !== 1'b1) begin errors++; $display("FAIL lock_valid_hi: got %b exp 1", rd_valid[0]); end
    step();
    rd_en = 0;
    checks++; if (count[0] !== 12'h0) begin errors++; $display("FAIL lock_pop: got %h exp 0", count[0]); end
  endtask
  task automatic test_overflow;
    do_reset();
    for (int i = 0; i < 4; i++) wr(32'h20 + 32'(4 * i), 32'h200 + 32'(i));
    checks++; if (full[0][2] !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b exp 1", full[0][2]); end
    checks++; if (err_ovf[0] !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b exp 0", err_ovf[0]); end
    wr(32'h2C, 32'h2FF);
    checks++; if (count[0][8:6] !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d exp 4", count[0][8:6]); end
    checks++; if (err_ovf[0] !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b exp 1", err_ovf[0]); end
    checks++; if (rd_data[0][95:64] !== 32'h200) begin errors++; $display("FAIL ovf_head: got %h exp 200", rd_data[0][95:64]); end
    err_clr = 1;
    step();
    err_clr = 0;
    checks++; if (err_ovf[0] !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b exp 0", err_ovf[0]); end
  endtask
  task automatic test_full_pop;
    do_reset();
    for (int i = 0; i < 4; i++) wr(32'h10, 32'h11 + 32'(i));
    rd_en = 1;
    rd_sel = 1;
    wr(32'h14, 32'h15);
    rd_en = 0;
    checks++; if (count[1][5:3] !== 3'd4) begin errors++; $display("FAIL fullpop_count: got %0d exp 4", count[1][5:3]); end
    checks++; if (err_ovf[1] !== 1'b0) begin errors++; $display("FAIL fullpop_ovf: got %b exp 0", err_ovf[1]); end
    checks++; if (rd_data[1][63:32] !== 32'h12) begin errors++; $display("FAIL fullpop_head: got %h exp 12", rd_data[1][63:32]); end
    checks++; if (err_ovf[0] !== 1'b1) begin errors++; $display("FAIL fullpop_lockstep_drop: got %b exp 1", err_ovf[0]); end
  endtask
  task automatic test_range;
    do_reset();
    wr(32'h40, 32'hDEAD);
    checks++; if (err_range[0] !== 1'b1 || err_range[1] !== 1'b1) begin errors++; $display("FAIL range_flag: got %b%b exp 11", err_range[0], err_range[1]); end
    checks++; if (count[0] !== 12'h0) begin errors++; $display("FAIL range_count: got %h exp 0", count[0]); end
    err_clr = 1;
    wr(32'h0FFF_FFFF, 32'h1);
    err_clr = 0;
    checks++; if (err_range[0] !== 1'b1) begin errors++; $display("FAIL range_set_wins: got %b exp 1", err_range[0]); end
    err_clr = 1;
    step();
    err_clr = 0;
    checks++; if (err_range[0] !== 1'b0) begin errors++; $display("FAIL range_clr: got %b exp 0", err_range[0]); end
    wr(32'hF000_0030, 32'h33);
    wr(32'h3F, 32'h34);
    checks++; if (count[0] !== 12'h400) begin errors++; $display("FAIL range_upper_bits: got %h exp 400", count[0]); end
    checks++; if (err_range[0] !== 1'b0) begin errors++; $display("FAIL range_boundary: got %b exp 0", err_range[0]); end
  endtask
  task automatic test_async_reset;
    do_reset();
    wr(32'h00, 32'h5);
    wr(32'h24, 32'h6);
    #2;
    rstn = 0;
    #1;
    checks++; if (empty[0] !== 4'hf || empty[1] !== 4'hf) begin errors++; $display("FAIL async_empty: got %h %h exp f f", empty[0], empty[1]); end
    checks++; if (count[0] !== 12'h0 || count[1] !== 12'h0) begin errors++; $display("FAIL async_count: got %h %h exp 0 0", count[0], count[1]); end
    checks++; if (rd_data[0] !== '0) begin errors++; $display("FAIL async_rd_data: got %h exp 0", rd_data[0]); end
    for (int m = 0; m < 2; m++) for (int i = 0; i < N; i++) q[m][i].delete();
    rstn = 1;
    wr(32'h18, 32'h77);
    checks++; if (count[0] !== 12'h008 || rd_data[0][63:32] !== 32'h77) begin errors++; $display("FAIL async_first_write: got %h/%h exp 008/77", count[0], rd_data[0][63:32]); end
  endtask
  task automatic test_random;
    int c;
    logic [W-1:0] h;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      wr_en = $urandom_range(0, 9) < 7;
      wr_addr = $urandom_range(0, 7) == 0 ? {4'($urandom), 28'($urandom_range(0, 'h4f))} : 32'($urandom_range(0, 'h4f));
      wr_data = $urandom;
      rd_en = $urandom_range(0, 1) == 1;
      rd_sel = 2'($urandom);
      err_clr = $urandom_range(0, 7) == 0;
      step();
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < N; i++) begin
          c = q[m][i].size();
          h = c > 0 ? q[m][i][0] : '0;
          checks++; if (count[m][i*3 +: 3] !== 3'(c)) begin errors++; $display("FAIL rnd_count m%0d ch%0d: got %0d exp %0d", m, i, count[m][i*3 +: 3], c); end
          checks++; if (rd_data[m][i*W +: W] !== h) begin errors++; $display("FAIL rnd_head m%0d ch%0d: got %h exp %h", m, i, rd_data[m][i*W +: W], h); end
          checks++; if (full[m][i] !== (c == D) || empty[m][i] !== (c == 0)) begin errors++; $display("FAIL rnd_flags m%0d ch%0d: got f%b e%b cnt %0d", m, i, full[m][i], empty[m][i], c); end
        end
        checks++; if (rd_valid[m] !== exp_valid(m)) begin errors++; $display("FAIL rnd_valid m%0d: got %b exp %b", m, rd_valid[m], exp_valid(m)); end
        checks++; if (err_ovf[m] !== m_ovf[m] || err_range[m] !== m_rng[m]) begin errors++; $display("FAIL rnd_err m%0d: got %b%b exp %b%b", m, err_ovf[m], err_range[m], m_ovf[m], m_rng[m]); end
      end
    end
    wr_en = 0;
    rd_en = 0;
    err_clr = 0;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_lockstep();
    test_overflow();
    test_full_pop();
    test_range();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
